// File: rtl/spi_cmd_tx.sv
// Slow-control serial command transmitter: sends an address byte plus 1..MAX_BYTES
// data bytes LSB first on a gated sclk with registered, glitch-free outputs.
module spi_cmd_tx #(
    parameter int unsigned MAX_BYTES = 4,
    parameter int unsigned CLK_DIV   = 2
) (
    input  logic                             iclk,
    input  logic                             rstn,
    input  logic                             start,
    input  logic [7:0]                       addr,
    input  logic [8*MAX_BYTES-1:0]           data,
    input  logic [$clog2(MAX_BYTES+1)-1:0]   num_bytes,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic                             sclk,
    output logic                             serial_out
);

    localparam int unsigned SH_W  = 8 * (MAX_BYTES + 1);
    localparam int unsigned CNT_W = $clog2(SH_W + 1);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t            r_state,  w_state_nx;
    logic [SH_W-1:0]   r_shift,  w_shift_nx;
    logic [CNT_W-1:0]  r_bits,   w_bits_nx;
    logic [DIV_W-1:0]  r_div,    w_div_nx;
    logic              r_busy,   w_busy_nx;
    logic              r_done,   w_done_nx;
    logic              r_err,    w_err_nx;
    logic              r_sclk,   w_sclk_nx;
    logic              r_so,     w_so_nx;

    logic              w_nb_ok;
    logic              w_div_end;
    logic [CNT_W-1:0]  w_frame_bits;

    assign w_nb_ok      = (num_bytes != '0) && (32'(num_bytes) <= MAX_BYTES);
    assign w_frame_bits = CNT_W'((32'(num_bytes) + 32'd1) << 3);
    assign w_div_end    = (r_div == DIV_W'(CLK_DIV - 1));

    // r_bits counts bits still to send including the one on serial_out
    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_bits_nx  = r_bits;
        w_div_nx   = r_div;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        w_sclk_nx  = r_sclk;
        w_so_nx    = r_so;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_nb_ok) begin
                        w_state_nx = S_LOW;
                        w_shift_nx = {data, addr};
                        w_bits_nx  = w_frame_bits;
                        w_div_nx   = '0;
                        w_busy_nx  = 1'b1;
                        w_sclk_nx  = 1'b0;
                        w_so_nx    = addr[0];
                    end else begin
                        w_err_nx   = 1'b1;
                    end
                end
            end
            S_LOW: begin
                if (w_div_end) begin
                    w_div_nx   = '0;
                    w_sclk_nx  = 1'b1;
                    w_state_nx = S_HIGH;
                end else begin
                    w_div_nx   = r_div + DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (w_div_end) begin
                    w_div_nx  = '0;
                    w_sclk_nx = 1'b0;
                    if (r_bits > CNT_W'(1)) begin
                        w_shift_nx = {1'b0, r_shift[SH_W-1:1]};
                        w_so_nx    = r_shift[1];
                        w_bits_nx  = r_bits - CNT_W'(1);
                        w_state_nx = S_LOW;
                    end else begin
                        w_so_nx    = 1'b0;
                        w_bits_nx  = '0;
                        w_done_nx  = 1'b1;
                        w_state_nx = S_DONE;
                    end
                end else begin
                    w_div_nx = r_div + DIV_W'(1);
                end
            end
            S_DONE: begin
                w_busy_nx  = 1'b0;
                w_shift_nx = '0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bits  <= '0;
            r_div   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_sclk  <= 1'b0;
            r_so    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_shift <= w_shift_nx;
            r_bits  <= w_bits_nx;
            r_div   <= w_div_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_sclk  <= w_sclk_nx;
            r_so    <= w_so_nx;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign sclk       = r_sclk;
    assign serial_out = r_so;

endmodule

// File: doc/spi_cmd_tx.md
Name: spi_cmd_tx

Overview:
- Serial command transmitter; the initiator end of the chip's slow-control serial link.
- Takes one address byte plus 1..MAX_BYTES data bytes from a host/FPGA-side register interface.
- Generates the gated serial clock and serial data that the on-chip serial receiver decodes into trigger_channel_mask, instruction and mode.
- Frame format: address byte first, then data bytes, every byte LSB first, no chip select.

Parameters:
- MAX_BYTES, 4: maximum data bytes per frame (excluding address).
- CLK_DIV, 2: iclk cycles per sclk half-period. Legal values are ≥1.

Ports:
- iclk  input  1  system clock; all logic on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle (or level) request; accepted only in IDLE.
- addr  input  8  register address byte.
- data  input  8*MAX_BYTES  payload; byte k = data[8k+7:8k], byte 0 sent first.
- num_bytes  input  $clog2(MAX_BYTES+1)  number of data bytes to send, legal range 1..MAX_BYTES.
- busy  output  1  high from the accept cycle through the DONE cycle.
- done  output  1  one-cycle pulse when the frame completes.
- err  output  1  one-cycle pulse when start is rejected because num_bytes is illegal.
- sclk  output  1  serial clock; idles low and toggles only during a frame.
- serial_out  output  1  serial data; idles low.

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-frame:
  - busy=0, done=0, err=0, sclk=0, serial_out=0.
  - State=IDLE; all counters and the shift register cleared.
  - Partial frame is abandoned; no done pulse.
- Output registration: all outputs come straight from flops (no combinational outputs, glitch-free sclk).
- State machine: IDLE -> LOW -> HIGH -> (LOW | DONE) -> IDLE.
- IDLE:
  - start=1 with num_bytes in 1..MAX_BYTES: latch addr, data and num_bytes. Next cycle busy=1, serial_out=addr[0], sclk=0, go to LOW.
  - start=1 with num_bytes=0 or >MAX_BYTES: err=1 for one cycle; stay IDLE; busy stays 0.
- LOW: sclk=0 for CLK_DIV cycles with the current bit held stable, then sclk=1 and go to HIGH.
- HIGH:
  - sclk=1 for CLK_DIV cycles, bit held stable; the receiver samples on sclk rising.
  - Then sclk=0 on the same edge as the change of serial_out.
  - If bits remain: serial_out = next bit, go to LOW.
  - After the last bit: serial_out=0, go to DONE.
- DONE: one cycle, busy=1, done=1, sclk=0; then IDLE with busy=0.
- Frame length: N = 8*(num_bytes+1) bits, hence exactly N sclk rising edges.
  - Bit order: addr[0..7], data byte0[0..7], byte1[0..7], ...
- Latency: busy high for exactly 2*CLK_DIV*N + 1 cycles. The first sclk rise occurs CLK_DIV cycles after busy rises.
- Bit counter width is $clog2(8*(MAX_BYTES+1)+1). It must not wrap at full frame size.
- start while busy (including the DONE cycle) is ignored; no err, no queueing. Input changes during a frame have no effect on it.
- start held high: a new frame is accepted on the first IDLE cycle after DONE, giving back-to-back frames with one IDLE cycle between them.

Test Plan:
- addr=8'h01, data byte0=8'hAA, num_bytes=1, CLK_DIV=2 -> 16 sclk rises. Bits sampled at the rises are 1,0,0,0,0,0,0,0,0,1,0,1,0,1,0,1. busy high for 65 cycles; done pulses once, in the final busy cycle.
- num_bytes=4, addr=8'h03, data=32'h07_55_FF_00 -> 40 sclk rises. A model of the serial receiver decodes addr 3, then bytes 00,FF,55,07. busy high for 161 cycles.
- start with num_bytes=0, then with num_bytes=5 -> err pulses one cycle each; busy, sclk and serial_out stay 0.
- start pulsed again at cycle 10 of an active frame, with different addr/data -> ignored; the frame contents are unchanged and there is exactly one done.
- rstn low for 1 cycle mid-frame (after 7 sclk rises) -> sclk, serial_out and busy go 0 asynchronously with no done pulse. A new start afterwards sends a complete, correct frame.
- start held high with CLK_DIV=1 -> back-to-back frames, each 2*N+1 busy cycles, separated by exactly one busy=0 cycle. sclk high for exactly 1 cycle per bit.
